// File: rtl/vx_nc_mem_responder.sv
// vx_nc_mem_responder: on-chip line store answering line-wide memory requests in order
module vx_nc_mem_responder #(
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int NUM_LINES  = 16,
  parameter int BASE_LINE  = 0,
  parameter int LATENCY    = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_req_valid,
  input  logic                   mem_req_rw,
  input  logic [LINE_SIZE-1:0]   mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic [LINE_SIZE*8-1:0] mem_req_data,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag,
  output logic                   mem_req_ready,
  output logic                   mem_rsp_valid,
  output logic [LINE_SIZE*8-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
  input  logic                   mem_rsp_ready,
  output logic                   busy,
  output logic                   addr_err
);
  localparam int DW = LINE_SIZE * 8;
  localparam int IW = $clog2(NUM_LINES);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  logic [1:0]            rst_sync;
  logic [DW-1:0]         store [NUM_LINES];
  logic [CW-1:0]         credits, count;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] off;
  logic [IW-1:0]         idx;
  logic                  hit, req_fire, rd_fire, wr_fire, rsp_fire, push;
  logic [LATENCY-1:0]    pipe_v;
  logic [DW-1:0]         pipe_d [LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_t [LATENCY];
  logic [DW-1:0]         fifo_d [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_t [RSP_DEPTH];
  assign off           = mem_req_addr - ADDR_WIDTH'(BASE_LINE);
  assign hit           = off < ADDR_WIDTH'(NUM_LINES);
  assign idx           = off[IW-1:0];
  assign mem_req_ready = rst_sync[1] && credits != '0;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw && hit;
  assign mem_rsp_valid = count != '0;
  assign mem_rsp_data  = fifo_d[rd_ptr];
  assign mem_rsp_tag   = fifo_t[rd_ptr];
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign push          = pipe_v[LATENCY-1];
  assign busy          = credits != CW'(RSP_DEPTH);
  // Requests stay blocked until reset release has been synchronised to clk.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) store[i] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < LINE_SIZE; i++)
        if (mem_req_byteen[i]) store[idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      credits  <= CW'(RSP_DEPTH);
      addr_err <= 1'b0;
      pipe_v   <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      credits   <= credits - CW'(rd_fire) + CW'(rsp_fire);
      addr_err  <= req_fire && !hit;
      pipe_v[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
      count <= count + CW'(push) - CW'(rsp_fire);
      if (push) wr_ptr <= wr_ptr == PW'(RSP_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (rsp_fire) rd_ptr <= rd_ptr == PW'(RSP_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
    end
  always_ff @(posedge clk) begin
    pipe_d[0] <= hit ? store[idx] : '0;
    pipe_t[0] <= mem_req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_t[i] <= pipe_t[i-1];
    end
    if (push) begin
      fifo_d[wr_ptr] <= pipe_d[LATENCY-1];
      fifo_t[wr_ptr] <= pipe_t[LATENCY-1];
    end
  end
  always_ff @(posedge clk)
    if (reset_n) begin
      assert (!(count == CW'(RSP_DEPTH) && |pipe_v));
      assert (!mem_rsp_valid || !$isunknown({mem_rsp_data, mem_rsp_tag}));
    end
endmodule

// File: tb/tb_vx_nc_mem_responder.sv
// tb_vx_nc_mem_responder: directed checks of store, latency, credits, ordering and reset
module tb_vx_nc_mem_responder;
  logic         clk = 0, reset_n = 0;
  logic         mem_req_valid = 0, mem_req_rw = 0, mem_rsp_ready = 1;
  logic [63:0]  mem_req_byteen = '0;
  logic [25:0]  mem_req_addr = '0;
  logic [511:0] mem_req_data = '0;
  logic [7:0]   mem_req_tag = '0;
  logic         mem_req_ready, mem_rsp_valid, busy, addr_err;
  logic [511:0] mem_rsp_data;
  logic [7:0]   mem_rsp_tag;
  int n_chk = 0, n_fail = 0;
  logic [511:0] a_line, rd;
  logic [7:0]   rt;
  int q[$];
  vx_nc_mem_responder dut (
    .clk(clk), .reset_n(reset_n), .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic rw, input logic [25:0] addr, input logic [63:0] be,
                      input logic [511:0] d, input logic [7:0] tag);
    mem_req_valid = 1; mem_req_rw = rw; mem_req_addr = addr;
    mem_req_byteen = be; mem_req_data = d; mem_req_tag = tag;
    for (int i = 0; i < 200 && !mem_req_ready; i++) step();
    if (!mem_req_ready) check("req_timeout", mem_req_ready, 1);
    step();
    mem_req_valid = 0;
  endtask
  task automatic get_rsp(output logic [511:0] d, output logic [7:0] t);
    for (int i = 0; i < 50 && !mem_rsp_valid; i++) step();
    if (!mem_rsp_valid) check("rsp_timeout", mem_rsp_valid, 1);
    d = mem_rsp_data;
    t = mem_rsp_tag;
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    a_line = {64{8'h01}};
    step(); step();
    check("rst_ready", mem_req_ready, 0);
    check("rst_valid", mem_rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_err", addr_err, 0);
    reset_n = 1;
    step(); step(); step();
    check("rst_rel_ready", mem_req_ready, 1);
    // full-line write then read, with exact latency
    send(1, 26'd3, '1, a_line, 8'h00);
    send(0, 26'd3, '0, '0, 8'h15);
    check("t1_lat0", mem_rsp_valid, 0);
    check("t1_busy", busy, 1);
    step();
    check("t1_lat1", mem_rsp_valid, 0);
    step();
    check("t1_lat2", mem_rsp_valid, 1);
    check("t1_data", mem_rsp_data, a_line);
    check("t1_tag", mem_rsp_tag, 8'h15);
    step();
    check("t1_idle", busy, 0);
    // byte-masked write
    send(1, 26'd3, 64'hFF, {64{8'hAA}}, 8'h00);
    send(0, 26'd3, '0, '0, 8'h22);
    get_rsp(rd, rt);
    check("t2_data", rd, {{56{8'h01}}, {8{8'hAA}}});
    check("t2_tag", rt, 8'h22);
    // credit exhaustion and in-order release
    begin
      int acc = 0;
      mem_rsp_ready = 0;
      mem_req_valid = 1; mem_req_rw = 0; mem_req_addr = 26'd3;
      for (int k = 0; k < 6; k++) begin
        mem_req_tag = 8'(acc);
        if (mem_req_ready) acc++;
        step();
      end
      mem_req_valid = 0;
      check("t3_accepted", 32'(acc), 4);
      check("t3_ready0", mem_req_ready, 0);
      check("t3_busy", busy, 1);
      check("t3_hold_tag", mem_rsp_tag, 8'h00);
      step();
      check("t3_hold_tag2", mem_rsp_tag, 8'h00);
      check("t3_hold_valid", mem_rsp_valid, 1);
      mem_rsp_ready = 1;
      fork
        begin
          send(0, 26'd3, '0, '0, 8'd4);
          send(0, 26'd3, '0, '0, 8'd5);
        end
        begin
          int n = 0;
          for (int c = 0; c < 100 && n < 6; c++) begin
            if (mem_rsp_valid) begin
              check("t3_order", mem_rsp_tag, 8'(n));
              n++;
            end
            step();
          end
          if (n < 6) check("t3_count", 32'(n), 6);
        end
      join
    end
    // out-of-range read and write
    send(0, 26'd16, '0, '0, 8'h33);
    check("t4_err_rd", addr_err, 1);
    step();
    check("t4_err_rd_off", addr_err, 0);
    get_rsp(rd, rt);
    check("t4_miss_data", rd, '0);
    check("t4_miss_tag", rt, 8'h33);
    send(1, 26'd16, '1, '1, 8'h00);
    check("t4_err_wr", addr_err, 1);
    step();
    check("t4_err_wr_off", addr_err, 0);
    send(0, 26'd0, '0, '0, 8'h34);
    get_rsp(rd, rt);
    check("t4_line0", rd, '0);
    // zero credits with a simultaneous handshake and new read
    mem_rsp_ready = 0;
    for (int k = 0; k < 4; k++) send(0, 26'd3, '0, '0, 8'(8'h30 + k));
    step(); step(); step();
    check("t5_ready0", mem_req_ready, 0);
    mem_req_valid = 1; mem_req_rw = 0; mem_req_addr = 26'd3; mem_req_tag = 8'h34;
    mem_rsp_ready = 1;
    check("t5_head30", mem_rsp_tag, 8'h30);
    step();
    check("t5_ready1", mem_req_ready, 1);
    check("t5_head31", mem_rsp_tag, 8'h31);
    step();
    mem_req_valid = 0;
    check("t5_credit_same", mem_req_ready, 1);
    check("t5_busy", busy, 1);
    for (int k = 2; k < 5; k++) begin
      get_rsp(rd, rt);
      check("t5_drain", rt, 8'(8'h30 + k));
    end
    // random stream with random response back-pressure
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          logic [7:0] t;
          t = 8'($urandom_range(0, 255));
          send(0, 26'd3, '0, '0, t);
          q.push_back(int'(t));
        end
      end
      begin
        int got = 0;
        for (int c = 0; c < 5000 && got < 100; c++) begin
          mem_rsp_ready = 1'($urandom_range(0, 1));
          if (mem_rsp_valid && mem_rsp_ready) begin
            int e;
            e = q.size() > 0 ? q.pop_front() : -1;
            check("t5_stream", {504'd0, mem_rsp_tag}, 512'(e));
            got++;
          end
          step();
        end
        if (got < 100) check("t5_stream_count", 32'(got), 100);
      end
    join
    mem_rsp_ready = 1;
    step(); step();
    check("t5_idle", busy, 0);
    // reset with reads in flight
    mem_rsp_ready = 0;
    for (int k = 0; k < 3; k++) send(0, 26'd3, '0, '0, 8'(8'h50 + k));
    reset_n = 0;
    #1;
    check("t6_valid", mem_rsp_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", mem_req_ready, 0);
    mem_rsp_ready = 1;
    step(); step();
    reset_n = 1;
    step(); step(); step();
    check("t6_no_stray", mem_rsp_valid, 0);
    check("t6_ready_rel", mem_req_ready, 1);
    send(0, 26'd3, '0, '0, 8'h66);
    get_rsp(rd, rt);
    check("t6_cleared", rd, '0);
    check("t6_tag", rt, 8'h66);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
